// File: rtl/pu_io_ctrl_pkg.sv
// Shared types and constants for the PU IO bus: command record, target
// index map and the pu_io_ctrl state encoding.
package pu_io_ctrl_pkg;

  localparam int PU_WIDTH_NBITS = 32;
  localparam int PU_ADDR_NBITS  = 16;
  localparam int PU_FID_NBITS   = 8;

  // Target-select field inside the command address
  localparam int PU_MEM_MULTI_DEPTH_LSB = 12;
  localparam int PU_MEM_MULTI_DEPTH_MSB = 15;
  localparam int TGT_FIELD_NBITS = PU_MEM_MULTI_DEPTH_MSB - PU_MEM_MULTI_DEPTH_LSB + 1;

  localparam int PU_CFG_MEM  = 0;
  localparam int PU_PD_MEM   = 1;
  localparam int PU_FLOW_MEM = 2;
  localparam int PU_STAT_MEM = 3;

  typedef struct packed {
    logic [PU_ADDR_NBITS-1:0]  addr;
    logic [PU_FID_NBITS-1:0]   fid;
    logic                      wr;
    logic [PU_WIDTH_NBITS-1:0] wdata;
  } io_type;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } io_state_e;

endpackage

// File: rtl/pu_io_ctrl.sv
// PU IO controller: forwards one PU command at a time to the memory targets,
// collects the single expected ack (or times out) and reports back to the PU.
module pu_io_ctrl
  import pu_io_ctrl_pkg::*;
#(
  parameter int NUM_OF_TGT    = 4,
  parameter int WIDTH_NBITS   = PU_WIDTH_NBITS,
  parameter int TIMEOUT_NBITS = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pu_req,
  input  io_type                            pu_cmd,
  output logic                              pu_busy,
  output logic                              pu_ack,
  output logic [WIDTH_NBITS-1:0]            pu_ack_data,
  output logic                              pu_err,
  output logic                              pu_viol,
  output logic                              io_req,
  output io_type                            io_cmd,
  input  logic [NUM_OF_TGT-1:0]             tgt_ack,
  input  logic [NUM_OF_TGT*WIDTH_NBITS-1:0] tgt_ack_data
);

  localparam logic [TGT_FIELD_NBITS-1:0] NUM_TGT_F = TGT_FIELD_NBITS'(NUM_OF_TGT);
  // Leaving WAIT on this value means the counter lands on all-ones.
  localparam logic [TIMEOUT_NBITS-1:0]   TMO_LAST  = {{(TIMEOUT_NBITS-1){1'b1}}, 1'b0};

  io_state_e                     state_r;
  logic [TGT_FIELD_NBITS-1:0]    exp_tgt_r;
  logic [TIMEOUT_NBITS-1:0]      tmo_cnt_r;

  logic [TGT_FIELD_NBITS-1:0]    req_field_s;
  logic                          req_mapped_s;
  logic [NUM_OF_TGT-1:0]         exp_mask_s;
  logic                          ack_ok_s;
  logic [WIDTH_NBITS-1:0]        sel_data_s;

  // Decode the incoming target field and qualify the returned ack vector.
  always_comb begin
    req_field_s  = pu_cmd.addr[PU_MEM_MULTI_DEPTH_MSB:PU_MEM_MULTI_DEPTH_LSB];
    req_mapped_s = (req_field_s < NUM_TGT_F);
    exp_mask_s   = {{(NUM_OF_TGT-1){1'b0}}, 1'b1} << exp_tgt_r;
    ack_ok_s     = (tgt_ack == exp_mask_s);
  end

  // Select the read data lane belonging to the expected target.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NUM_OF_TGT; i++) begin
      if (exp_tgt_r == TGT_FIELD_NBITS'(i)) begin
        sel_data_s = tgt_ack_data[i*WIDTH_NBITS +: WIDTH_NBITS];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Transaction FSM with all PU- and target-facing outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      exp_tgt_r   <= '0;
      tmo_cnt_r   <= '0;
      pu_busy     <= 1'b0;
      pu_ack      <= 1'b0;
      pu_ack_data <= '0;
      pu_err      <= 1'b0;
      pu_viol     <= 1'b0;
      io_req      <= 1'b0;
      io_cmd      <= '0;
    end else begin
      pu_ack      <= 1'b0;
      pu_ack_data <= '0;
      pu_err      <= 1'b0;
      io_req      <= 1'b0;
      pu_viol     <= pu_req & pu_busy;
      case (state_r)
        ST_IDLE: begin
          if (pu_req) begin
            pu_busy <= 1'b1;
            if (req_mapped_s) begin
              io_cmd    <= pu_cmd;
              exp_tgt_r <= req_field_s;
              io_req    <= 1'b1;
              state_r   <= ST_ISSUE;
            end else begin
              pu_ack  <= 1'b1;
              pu_err  <= 1'b1;
              state_r <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          tmo_cnt_r <= '0;
          state_r   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tgt_ack != '0) begin
            pu_ack  <= 1'b1;
            state_r <= ST_RESP;
            if (ack_ok_s) begin
              pu_ack_data <= io_cmd.wr ? '0 : sel_data_s;
            end else begin
              pu_err <= 1'b1;
            end
          end else begin
            tmo_cnt_r <= tmo_cnt_r + {{(TIMEOUT_NBITS-1){1'b0}}, 1'b1};
            if (tmo_cnt_r == TMO_LAST) begin
              pu_ack  <= 1'b1;
              pu_err  <= 1'b1;
              state_r <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          pu_busy <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          pu_busy <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pu_io_ctrl.sv
// Directed, table-driven bench for pu_io_ctrl with hand-written sequences for
// reset-in-flight and late-ack corner cases.
module tb_pu_io_ctrl;
  import pu_io_ctrl_pkg::*;

  localparam int NT = 4;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          pu_req;
  io_type        pu_cmd;
  logic          pu_busy, pu_ack, pu_err, pu_viol, io_req;
  logic [W-1:0]  pu_ack_data;
  io_type        io_cmd;
  logic [NT-1:0] tgt_ack;
  logic [NT*W-1:0] tgt_ack_data;

  int n_chk  = 0;
  int n_fail = 0;

  pu_io_ctrl #(.NUM_OF_TGT(NT), .WIDTH_NBITS(W), .TIMEOUT_NBITS(10)) dut (
    .clk(clk), .rst(rst), .pu_req(pu_req), .pu_cmd(pu_cmd),
    .pu_busy(pu_busy), .pu_ack(pu_ack), .pu_ack_data(pu_ack_data),
    .pu_err(pu_err), .pu_viol(pu_viol), .io_req(io_req), .io_cmd(io_cmd),
    .tgt_ack(tgt_ack), .tgt_ack_data(tgt_ack_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  field;
    logic        wr;
    logic [31:0] wdata;
    int          d;          // ack cycle offset after the io_req cycle
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_ack_cyc; // pu_ack cycle, counting the cycle after pu_req as 1
    logic        exp_ioreq;
    int          viol_at;     // 0 = no pu_req while busy
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] f, input logic wr, input int d,
                              input logic [3:0] m, input logic [31:0] data,
                              input logic [31:0] ed, input logic ee, input int ec,
                              input logic eio, input int va);
    vec_t v;
    v.field = f; v.wr = wr; v.wdata = 32'h55AA_0000 | 32'(f); v.d = d; v.mask = m;
    v.data = data; v.exp_data = ed; v.exp_err = ee; v.exp_ack_cyc = ec;
    v.exp_ioreq = eio; v.viol_at = va;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    io_type cmd, vcmd;
    int ack_k, busy_n, ioreq_n;
    logic [31:0] got_d;
    logic got_e;
    cmd = '0;
    cmd.addr = {v.field, 12'h0A5};
    cmd.fid = 8'(idx);
    cmd.wr = v.wr;
    cmd.wdata = v.wdata;
    vcmd = cmd;
    vcmd.addr = 16'h0123;
    for (int i = 0; i < NT; i++) begin
      tgt_ack_data[i*W +: W] = (32'(i) == 32'(v.field)) ? v.data : (32'hBAD0_0000 | 32'(i));
    end
    ack_k = 0; busy_n = 0; ioreq_n = 0; got_d = '0; got_e = 1'b0;
    pu_req = 1'b1;
    pu_cmd = cmd;
    tick();
    for (int k = 1; k <= 1200 && ack_k == 0; k++) begin
      if (pu_busy) busy_n++;
      if (io_req) ioreq_n++;
      if (k == 1 && v.exp_ioreq) check($sformatf("v%0d io_cmd", idx), 128'(io_cmd), 128'(cmd));
      check($sformatf("v%0d pu_viol k%0d", idx, k), 128'(pu_viol),
            128'(v.viol_at != 0 && k == v.viol_at + 1));
      if (pu_ack) begin
        ack_k = k; got_d = pu_ack_data; got_e = pu_err;
        pu_req = 1'b0; tgt_ack = '0;
      end else begin
        check($sformatf("v%0d idle data k%0d", idx, k), 128'({pu_ack_data, pu_err}), 128'(0));
        pu_req = (k == v.viol_at);
        pu_cmd = (k == v.viol_at) ? vcmd : cmd;
        tgt_ack = (v.mask != 4'h0 && k == 1 + v.d) ? v.mask : 4'h0;
        tick();
      end
    end
    check($sformatf("v%0d ack_seen", idx), 128'(ack_k != 0), 128'(1));
    check($sformatf("v%0d ack_cycle", idx), 128'(ack_k), 128'(v.exp_ack_cyc));
    check($sformatf("v%0d ack_data", idx), 128'(got_d), 128'(v.exp_data));
    check($sformatf("v%0d ack_err", idx), 128'(got_e), 128'(v.exp_err));
    check($sformatf("v%0d io_req_count", idx), 128'(ioreq_n), 128'(v.exp_ioreq ? 1 : 0));
    check($sformatf("v%0d busy_cycles", idx), 128'(busy_n), 128'(v.exp_ack_cyc));
    if (v.exp_ioreq) check($sformatf("v%0d io_cmd_held", idx), 128'(io_cmd), 128'(cmd));
    tick();
    check($sformatf("v%0d post ack/busy", idx), 128'({pu_ack, pu_busy, pu_err}), 128'(0));
  endtask

  task automatic check_all_zero(input string name);
    check({name, " busy"}, 128'(pu_busy), 128'(0));
    check({name, " ack"}, 128'(pu_ack), 128'(0));
    check({name, " data"}, 128'(pu_ack_data), 128'(0));
    check({name, " err"}, 128'(pu_err), 128'(0));
    check({name, " viol"}, 128'(pu_viol), 128'(0));
    check({name, " io_req"}, 128'(io_req), 128'(0));
    check({name, " io_cmd"}, 128'(io_cmd), 128'(0));
  endtask

  initial begin
    io_type c;
    //            field  wr  d   mask  data           exp_data       err ackc io  viol
    vecs[0] = mk(4'd2,  1'b0, 3, 4'b0100, 32'h0000_1234, 32'h0000_1234, 1'b0, 5,    1'b1, 0);
    vecs[1] = mk(4'd1,  1'b1, 2, 4'b0010, 32'h0000_7777, 32'h0,         1'b0, 4,    1'b1, 0);
    vecs[2] = mk(4'd4,  1'b0, 1, 4'b0000, 32'h0,         32'h0,         1'b1, 1,    1'b0, 0);
    vecs[3] = mk(4'd0,  1'b0, 1, 4'b0011, 32'h0000_9999, 32'h0,         1'b1, 3,    1'b1, 0);
    vecs[4] = mk(4'd3,  1'b0, 2, 4'b0001, 32'h0000_4444, 32'h0,         1'b1, 4,    1'b1, 0);
    vecs[5] = mk(4'd0,  1'b0, 1, 4'b0001, 32'hABCD_0123, 32'hABCD_0123, 1'b0, 3,    1'b1, 0);
    vecs[6] = mk(4'd15, 1'b1, 1, 4'b0000, 32'h0,         32'h0,         1'b1, 1,    1'b0, 0);
    vecs[7] = mk(4'd3,  1'b0, 10, 4'b1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 12,  1'b1, 0);
    vecs[8] = mk(4'd2,  1'b0, 4, 4'b0100, 32'h00C0_FFEE, 32'h00C0_FFEE, 1'b0, 6,    1'b1, 3);
    vecs[9] = mk(4'd1,  1'b0, 1, 4'b0000, 32'h0,         32'h0,         1'b1, 1025, 1'b1, 0);

    rst = 1'b1; pu_req = 1'b0; pu_cmd = '0; tgt_ack = '0; tgt_ack_data = '0;
    tick(); tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Late ack about five cycles after the timeout response is ignored.
    tick(); tick(); tick(); tick();
    tgt_ack = 4'b0010;
    tick();
    tgt_ack = '0;
    check("late_ack ack/busy/err", 128'({pu_ack, pu_busy, pu_err, io_req}), 128'(0));
    tick();
    check("late_ack settle", 128'({pu_ack, pu_busy, pu_err}), 128'(0));

    // Reset while WAITing abandons the transaction; a following ack is dropped.
    c = '0;
    c.addr = 16'h1000;
    pu_req = 1'b1; pu_cmd = c;
    tick();
    pu_req = 1'b0;
    check("rst_mid io_req", 128'(io_req), 128'(1));
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("rst_mid");
    tgt_ack = 4'b0010;
    tick();
    tgt_ack = '0;
    check("rst_mid post ack", 128'({pu_ack, pu_busy, pu_err}), 128'(0));
    tick();
    check("rst_mid idle", 128'({pu_ack, pu_busy}), 128'(0));
    run_vec(10, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pu_io_ctrl.md
PU_IO_CTRL -- requirements
Module: pu_io_ctrl

Interface
REQ-001 Parameter NUM_OF_TGT, default 4, is the number of memory targets on the PU IO bus.
REQ-002 Parameter WIDTH_NBITS, default `PU_WIDTH_NBITS, is the IO data width.
REQ-003 Parameter TIMEOUT_NBITS, default 10, is the width of the ack-timeout counter.
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 `RESET_SIG  input  1  reset, synchronous, active-high.
REQ-006 pu_req  input  1  single-cycle PU IO request strobe.
REQ-007 pu_cmd  input  io_type  PU command (addr, fid, wr, wdata), valid with pu_req.
REQ-008 pu_busy  output  1  transaction outstanding; PU shall not assert pu_req.
REQ-009 pu_ack  output  1  single-cycle completion pulse to the PU.
REQ-010 pu_ack_data  output  WIDTH_NBITS  read data; 0 on writes and on errors.
REQ-011 pu_err  output  1  qualifies pu_ack: unmapped, timeout or multi-ack.
REQ-012 pu_viol  output  1  one-cycle pulse: pu_req received while busy.
REQ-013 io_req  output  1  one-cycle request broadcast to all targets.
REQ-014 io_cmd  output  io_type  registered copy of pu_cmd, held stable until the next accept.
REQ-015 tgt_ack  input  NUM_OF_TGT  per-target ack pulses.
REQ-016 tgt_ack_data  input  WIDTH_NBITS x NUM_OF_TGT  per-target ack data, valid with tgt_ack.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE + pu_req, with addr[`PU_MEM_MULTI_DEPTH_RANGE] < NUM_OF_TGT: latch pu_cmd into io_cmd, latch that field as exp_tgt, go to ISSUE.
REQ-019 IDLE + pu_req, with field >= NUM_OF_TGT (unmapped): no io_req; go to RESP with err=1 and data=0.
REQ-020 ISSUE: io_req=1 for exactly one cycle; clear timeout counter; go to WAIT.
REQ-021 WAIT: first cycle where tgt_ack != 0 -> go to RESP.
  - Exactly one bit set and equal to exp_tgt: err=0; data = tgt_ack_data[exp_tgt] for reads, 0 for writes.
  - Wrong bit or more than one bit set: err=1, data=0.
REQ-022 WAIT: counter increments every cycle without an ack; when it reaches all-ones with no ack: go to RESP, err=1, data=0.
REQ-023 RESP: pu_ack=1 for one cycle with registered pu_ack_data/pu_err; go to IDLE.
REQ-024 pu_busy=1 in ISSUE, WAIT and RESP; pu_busy=0 in IDLE.
REQ-025 Latency: accept in cycle N -> io_req in N+1; ack in cycle M -> pu_ack in M+1; unmapped -> pu_ack in N+1.
REQ-026 tgt_ack in IDLE, ISSUE or RESP (late ack after timeout) is discarded; it does not alter data or state.
REQ-027 Accept occurs only in IDLE; the accepting cycle leaves IDLE at the next edge. Back-to-back minimum period is 4 cycles.
REQ-028 pu_req while pu_busy=1: command dropped; pu_viol pulses in the next cycle; state unaffected.
REQ-029 pu_ack_data and pu_err are 0 whenever pu_ack=0.

Reset
REQ-030 Reset forces: state=IDLE, pu_busy=0, pu_ack=0, pu_ack_data=0, pu_err=0, pu_viol=0, io_req=0, timeout counter=0, io_cmd=0.
REQ-031 Reset mid-transaction abandons the transaction without a pu_ack; a target ack arriving after reset is discarded per REQ-026.

Structure
REQ-032 io_type, `PU_MEM_MULTI_DEPTH_RANGE, `PU_WIDTH_NBITS and the target-index constants (including `PU_FLOW_MEM) come from type_package/defines.vh; the FSM state enum is also placed in type_package.
REQ-033 Single flat module with no sub-modules; one instance per PU at the PU IO boundary.
REQ-034 pu_io_ctrl drives the io_req/io_cmd inputs of pu_flow_pd_mem and the other PU memory targets, and consumes their io_ack/io_ack_data.

Verification
REQ-035 Read to target `PU_FLOW_MEM: tgt_ack[`PU_FLOW_MEM] 3 cycles after io_req with data 0x1234 -> pu_ack with data 0x1234, err=0; busy high for 5 cycles.
REQ-036 Write to target 1: tgt_ack[1] returned -> pu_ack with data 0, err=0.
REQ-037 Unmapped field value = NUM_OF_TGT -> no io_req; pu_ack 1 cycle after pu_req with err=1.
REQ-038 No ack returned -> pu_ack with err=1 exactly 1023 WAIT cycles later (TIMEOUT_NBITS=10); a tgt_ack 5 cycles after that is ignored.
REQ-039 Multi-ack: tgt_ack=4'b0011 -> err=1, data=0. pu_req during WAIT -> pu_viol pulse and the first transaction completes normally.
REQ-040 Reset asserted during WAIT -> all outputs 0 next cycle; a fresh read then completes normally.
